// File: rtl/dog_pkg.sv
// Shared constants and types for the DoG 3x3 spatial-extremum detector.
// Default geometry matches a VGA layer fed by a 10-bit signed DoG subtractor.
package dog_pkg;

  localparam int COLS  = 640;
  localparam int ROWS  = 480;
  localparam int DOG_W = 10;
  localparam int XW    = 10;
  localparam int YW    = 9;

  typedef logic signed [DOG_W-1:0] dog_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dog_line_buffer.sv
// Single-port, read-before-write row store: the old word at addr_i is visible
// combinationally in the same cycle that the new word is written.
module dog_line_buffer
  import dog_pkg::*;
#(
  parameter int DEPTH = COLS,
  parameter int AW    = XW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  dog_t          wdata_i,
  output dog_t          rdata_o
);

  dog_t mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // NOTE: storage arrays are deliberately left out of reset; stale rows are
  // never consumed because the top gates candidates until y >= 2.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/dog_extrema_3x3.sv
// Streaming 3x3 strict local max/min detector over one raster DoG layer,
// emitting (x, y, polarity) one cycle after the pixel that completes a window.
module dog_extrema_3x3
  import dog_pkg::*;
#(
  parameter int COLS   = dog_pkg::COLS,
  parameter int ROWS   = dog_pkg::ROWS,
  parameter int THRESH = 3,
  parameter int XW     = dog_pkg::XW,
  parameter int YW     = dog_pkg::YW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [DOG_W-1:0] in_dog,
  output logic                    kpt_valid,
  output logic [XW-1:0]           kpt_x,
  output logic [YW-1:0]           kpt_y,
  output logic                    kpt_max,
  output logic                    frame_done,
  output logic                    busy
);

  // Threshold held one bit wider so that -THRESH can never overflow DOG_W.
  localparam logic signed [DOG_W:0] THR_POS = (DOG_W+1)'(THRESH);
  localparam logic signed [DOG_W:0] THR_NEG = -THR_POS;

  state_e        state_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  dog_t          win_q [3][3];
  dog_t          win_d [3][3];
  dog_t          lb0_rd, lb1_rd;
  logic          kpt_valid_q, kpt_max_q, frame_done_q;
  logic [XW-1:0] kpt_x_q;
  logic [YW-1:0] kpt_y_q;

  logic last_x, last_y, last_px, candidate;
  logic gt_all, lt_all, is_max, is_min;
  dog_t                    centre;
  logic signed [DOG_W:0]   centre_ext;

  assign last_x  = (x_q == XW'(COLS - 1));
  assign last_y  = (y_q == YW'(ROWS - 1));
  assign last_px = last_x && last_y;

  // lb0 holds row y-1, lb1 holds row y-2; lb1 is refilled from lb0's old word.
  dog_line_buffer #(.DEPTH(COLS), .AW(XW)) u_lb0 (
    .clk    (clk),
    .we_i   (in_valid),
    .addr_i (x_q),
    .wdata_i(in_dog),
    .rdata_o(lb0_rd)
  );

  dog_line_buffer #(.DEPTH(COLS), .AW(XW)) u_lb1 (
    .clk    (clk),
    .we_i   (in_valid),
    .addr_i (x_q),
    .wdata_i(lb0_rd),
    .rdata_o(lb1_rd)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (in_valid) begin
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Window rows: 0 = y-2, 1 = y-1, 2 = y; columns: 0 = oldest, 2 = newest.
  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = in_dog;
    end
  end

  // Compare on the window as it will stand after this pixel, so the result
  // can be registered with a single cycle of latency.
  always_comb begin
    centre = win_d[1][1];
    gt_all = 1'b1;
    lt_all = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!(r == 1 && c == 1)) begin
          if (!(centre > win_d[r][c])) gt_all = 1'b0;
          if (!(centre < win_d[r][c])) lt_all = 1'b0;
        end
      end
    end
  end

  assign centre_ext = {centre[DOG_W-1], centre};
  assign is_max     = gt_all && (centre_ext > THR_POS);
  assign is_min     = lt_all && (centre_ext < THR_NEG);
  // x,y >= 2 excludes the borders and any window straddling a line wrap.
  assign candidate  = (x_q >= XW'(2)) && (y_q >= YW'(2));

  // NOTE: sequential state uses non-blocking assignments only; blocking
  // assignments are reserved for the combinational blocks above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      kpt_valid_q  <= 1'b0;
      kpt_x_q      <= '0;
      kpt_y_q      <= '0;
      kpt_max_q    <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      end
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      win_q        <= win_d;
      frame_done_q <= in_valid && last_px;
      kpt_valid_q  <= in_valid && candidate && (is_max || is_min);
      if (in_valid && candidate && (is_max || is_min)) begin
        kpt_x_q   <= x_q - XW'(1);
        kpt_y_q   <= y_q - YW'(1);
        kpt_max_q <= is_max;
      end
      case (state_q)
        IDLE:    if (in_valid) state_q <= RUN;
        RUN:     if (in_valid && last_px) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kpt_valid  = kpt_valid_q;
  assign kpt_x      = kpt_x_q;
  assign kpt_y      = kpt_y_q;
  assign kpt_max    = kpt_max_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_dog_extrema_3x3.sv
// Directed bench for dog_extrema_3x3 on an 8x6 layer: expected keypoints are
// derived from a full-frame image model and queued, then matched to DUT output.
module tb_dog_extrema_3x3;

  localparam int COLS   = 8;
  localparam int ROWS   = 6;
  localparam int THRESH = 3;
  localparam int XW     = 10;
  localparam int YW     = 9;
  localparam int DOG_W  = 10;
  localparam int NPIX   = COLS * ROWS;

  typedef struct {
    int x;
    int y;
    bit mx;
    int due;
  } ev_t;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic signed [DOG_W-1:0] in_dog;
  logic                    kpt_valid;
  logic [XW-1:0]           kpt_x;
  logic [YW-1:0]           kpt_y;
  logic                    kpt_max;
  logic                    frame_done;
  logic                    busy;

  int  img [ROWS][COLS];
  ev_t sb[$];
  int  cyc      = 0;
  int  fd_due   = -10;
  int  ev_count = 0;
  int  fd_count = 0;
  int  errors   = 0;
  int  checks   = 0;

  dog_extrema_3x3 #(
    .COLS(COLS), .ROWS(ROWS), .THRESH(THRESH), .XW(XW), .YW(YW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_dog    (in_dog),
    .kpt_valid (kpt_valid),
    .kpt_x     (kpt_x),
    .kpt_y     (kpt_y),
    .kpt_max   (kpt_max),
    .frame_done(frame_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: strict 3x3 extremum straight from the stored frame image.
  function automatic bit [1:0] model(input int cx, input int cy);
    int c  = img[cy][cx];
    bit mx = (c > THRESH);
    bit mn = (c < -THRESH);
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx != 0 || dy != 0) begin
          int n = img[cy+dy][cx+dx];
          if (!(c > n)) mx = 1'b0;
          if (!(c < n)) mn = 1'b0;
        end
      end
    end
    return {mx | mn, mx};
  endfunction

  // Output monitor: every cycle kpt_valid and frame_done must match the queue.
  always @(negedge clk) begin
    bit  exp_v;
    ev_t e;
    if (!rst) begin
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      check("kpt_valid", 32'(kpt_valid), 32'(exp_v));
      if (exp_v) begin
        e = sb.pop_front();
        if (kpt_valid) begin
          ev_count++;
          check("kpt_event", 32'({kpt_x, kpt_y, kpt_max}),
                32'({XW'(e.x), YW'(e.y), e.mx}));
        end
      end
      check("frame_done", 32'(frame_done), 32'(cyc == fd_due));
      if (frame_done) fd_count++;
    end
  end

  task automatic fill_img(input int v);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) img[y][x] = v;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_dog   = DOG_W'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input bit gaps);
    int     x = i % COLS;
    int     y = i / COLS;
    bit [1:0] m;
    ev_t    e;
    if (gaps) repeat ($urandom_range(0, 3)) idle();
    @(negedge clk);
    in_valid = 1'b1;
    in_dog   = DOG_W'(img[y][x]);
    if (x >= 2 && y >= 2) begin
      m = model(x - 1, y - 1);
      if (m[1]) begin
        e.x = x - 1; e.y = y - 1; e.mx = m[0]; e.due = cyc + 1;
        sb.push_back(e);
      end
    end
    if (i == NPIX - 1) fd_due = cyc + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy", 32'(busy), 32'(i != NPIX - 1));
  endtask

  task automatic run_frame(input string tag, input bit gaps, input int exp_ev);
    ev_count = 0;
    fd_count = 0;
    for (int i = 0; i < NPIX; i++) send(i, gaps);
    repeat (3) idle();
    check({tag, "_events"}, 32'(ev_count), 32'(exp_ev));
    check({tag, "_fd_count"}, 32'(fd_count), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    fd_due = -10;
    @(posedge clk);
    #1;
    check("rst_kpt_valid", 32'(kpt_valid), 32'd0);
    check("rst_kpt_x", 32'(kpt_x), 32'd0);
    check("rst_kpt_y", 32'(kpt_y), 32'd0);
    check("rst_kpt_max", 32'(kpt_max), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    ev_count = 0;
    fd_count = 0;
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_dog   = '0;
    do_reset();

    fill_img(0);
    run_frame("zero", 1'b0, 0);

    fill_img(0); img[2][3] = 20;
    run_frame("pos_3_2", 1'b0, 1);

    fill_img(0); img[4][5] = -20;
    run_frame("neg_5_4", 1'b0, 1);

    fill_img(0); img[4][5] = -3;
    run_frame("neg_thresh", 1'b0, 0);

    fill_img(0); img[2][3] = 20; img[2][4] = 20;
    run_frame("tie", 1'b0, 0);

    fill_img(0); img[2][0] = 20; img[3][7] = 20;
    run_frame("border", 1'b0, 0);

    fill_img(0); img[2][3] = 20; img[4][5] = -20; img[1][1] = 9;
    run_frame("multi", 1'b0, 3);
    run_frame("multi_gaps", 1'b1, 3);

    fill_img(-511); img[2][3] = -512; img[3][5] = 511;
    run_frame("extreme", 1'b0, 2);

    // Abort a frame mid-way; nothing from it may surface after reset.
    fill_img(0); img[2][3] = 20;
    for (int i = 0; i <= 20; i++) send(i, 1'b0);
    idle();
    do_reset();
    fill_img(0); img[1][2] = 20;
    run_frame("after_rst", 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dog_extrema_3x3.md
Name: dog_extrema_3x3

Overview:
- Streaming spatial-extremum detector. Sits directly downstream of the signed DoG subtractor, which produces a 10-bit signed difference of two 9-bit blurred pixels.
- Consumes one raster-ordered DoG layer (COLS x ROWS) and buffers two lines to form a 3x3 window.
- Emits a keypoint event (x, y, polarity) for every interior pixel that is a strict local max or min beyond a contrast threshold.
- Output feeds the keypoint collector for the layer.

Parameters:
- COLS, 640, pixels per line
- ROWS, 480, lines per frame
- DOG_W, 10, signed DoG sample width
- THRESH, 3, non-negative contrast threshold, compared signed against the centre
- XW, 10, column coordinate width; must satisfy 2^XW >= COLS
- YW, 9, row coordinate width; must satisfy 2^YW >= ROWS

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  in_dog carries the next raster pixel
- in_dog  in  DOG_W  signed DoG sample
- kpt_valid  out  1  one-cycle keypoint event
- kpt_x  out  XW  column of the keypoint centre
- kpt_y  out  YW  row of the keypoint centre
- kpt_max  out  1  1 = local maximum, 0 = local minimum
- frame_done  out  1  one-cycle pulse after the last pixel of the frame
- busy  out  1  high while in state RUN

Behaviour:
- Reset: all outputs 0, x=0, y=0, state IDLE, window registers 0. Line-buffer contents are don't-care.
- Reset mid-frame aborts the frame. The next in_valid is treated as pixel (0,0).
- in_valid low: nothing advances; bubbles of any length are allowed.
- State machine:
  - IDLE -> RUN on in_valid.
  - RUN -> IDLE on the in_valid accepting pixel (COLS-1, ROWS-1).
  - frame_done asserts the cycle after that transition.
  - busy = (state == RUN).
- Counters, on each in_valid:
  - x increments; at COLS-1 it wraps to 0 and y increments.
  - At (COLS-1, ROWS-1) both wrap to 0.
- Line buffers, two COLS-deep, read-before-write at address x on each in_valid:
  - lb0[x] holds row y-1; lb1[x] holds row y-2.
  - Write lb0[x] <= in_dog and lb1[x] <= old lb0[x].
- Window: 3 columns x 3 rows of DOG_W registers.
  - On in_valid, shift left by one column.
  - New right column = {lb1[x], lb0[x], in_dog}.
- Centre: after accepting pixel (x, y), the window centre is pixel (x-1, y-1).
- Candidate: requires x >= 2 and y >= 2. This gates out all border pixels and any window spanning a line wrap.
- Test, all comparisons signed:
  - max: centre > each of the 8 neighbours AND centre > THRESH.
  - min: centre < each of the 8 neighbours AND centre < -THRESH.
  - Any tie with a neighbour means not an extremum. A flat region gives no event.
- Output register, latency 1 cycle after the accepting in_valid edge:
  - kpt_valid = candidate & (max | min).
  - kpt_x = x-1, kpt_y = y-1, kpt_max = max.
  - When kpt_valid = 0, kpt_x, kpt_y and kpt_max hold their last values.
- frame_done and a final kpt_valid can coincide. No event is ever generated for row ROWS-1 or column COLS-1.
- Arithmetic: -THRESH is formed at DOG_W+1 bits to avoid overflow. The extreme values -512 and +511 are compared exactly.

Decomposition:
- Package dog_pkg:
  - constants COLS, ROWS, DOG_W, XW, YW
  - typedef dog_t (signed DOG_W)
  - state enum {IDLE, RUN}
- One sub-module: dog_line_buffer, a COLS-deep single-port read-before-write row store, instantiated twice.
- The window, compare tree and FSM stay in the top module.

Test Plan (COLS=8, ROWS=6, THRESH=3 unless noted):
- All-zero frame of 48 pixels -> no kpt_valid; frame_done pulses exactly once, 1 cycle after pixel 47; busy high from pixel 0 through pixel 47.
- Zero frame, +20 at (3,2) -> exactly one event: kpt_x=3, kpt_y=2, kpt_max=1, asserted 1 cycle after pixel (4,3) is accepted.
- Zero frame, -20 at (5,4) -> one event at (5,4) with kpt_max=0. Repeat with -3 -> no event (threshold is strict).
- Zero frame, +20 at (3,2) and +20 at (4,2) (tie) -> no event. Also +20 at (0,2) and at (7,3) (borders) -> no event.
- Event-producing frame sent with a random in_valid gap pattern -> event set and coordinates identical to the gap-free run. Extremes: -512 centre with -511 neighbours -> min event.
- rst pulsed mid-frame after pixel 20, then a full frame with +20 at (2,1) -> one event at (2,1); nothing emitted from the aborted frame after reset.
